// File: rtl/mux4_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mux4_arbiter
// Description : Round-robin arbiter with bounded hold time, steering a shared
//               4-to-1 single-bit data path to the current owner.
// Revision    : 1.0 - initial release
// ============================================================================
module mux4_arbiter #(
   parameter int MAX_HOLD = 4
) (
   input  logic       clock,
   input  logic       clear,
   input  logic [3:0] req,
   input  logic       i0,
   input  logic       i1,
   input  logic       i2,
   input  logic       i3,
   output logic [3:0] gnt,
   output logic       s1,
   output logic       s0,
   output logic       valid,
   output logic       out
);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

   state_t     state, state_nxt;
   logic [1:0] last_owner, last_owner_nxt;
   logic [3:0] hold_cnt, hold_cnt_nxt;
   logic [3:0] gnt_nxt;
   logic [1:0] sel_nxt;
   logic       valid_nxt;
   logic [1:0] cand;
   logic [1:0] win_idx;
   logic       win_found;
   logic       release_now;

   // Round-robin search starting just after the last owner; k=4 wraps to
   // the last owner itself so a lone expiring requester can be re-granted.
   always_comb begin
      win_found = 1'b0;
      win_idx   = last_owner;
      cand      = last_owner;
      for (int k = 1; k <= 4; k++) begin
         cand = last_owner + 2'(k);
         if (!win_found && req[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

   // While in GRANT the owner is always last_owner.
   always_comb begin
      state_nxt      = state;
      last_owner_nxt = last_owner;
      hold_cnt_nxt   = hold_cnt;
      gnt_nxt        = gnt;
      sel_nxt        = {s1, s0};
      valid_nxt      = valid;
      release_now    = (state == IDLE) || !req[last_owner] || (hold_cnt == HOLD_LAST);
      if (release_now) begin
         hold_cnt_nxt = 4'd0;
         if (win_found) begin
            state_nxt      = GRANT;
            last_owner_nxt = win_idx;
            gnt_nxt        = 4'b0001 << win_idx;
            sel_nxt        = win_idx;
            valid_nxt      = 1'b1;
         end else begin
            state_nxt = IDLE;
            gnt_nxt   = 4'b0000;
            valid_nxt = 1'b0;
         end
      end else begin
         hold_cnt_nxt = hold_cnt + 4'd1;
      end
   end

   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         state      <= IDLE;
         last_owner <= 2'd3;
         hold_cnt   <= 4'd0;
         gnt        <= 4'b0000;
         s1         <= 1'b0;
         s0         <= 1'b0;
         valid      <= 1'b0;
      end else begin
         state      <= state_nxt;
         last_owner <= last_owner_nxt;
         hold_cnt   <= hold_cnt_nxt;
         gnt        <= gnt_nxt;
         s1         <= sel_nxt[1];
         s0         <= sel_nxt[0];
         valid      <= valid_nxt;
      end
   end

   always_comb begin
      out = 1'b0;
      if (valid) begin
         case ({s1, s0})
            2'd0:    out = i0;
            2'd1:    out = i1;
            2'd2:    out = i2;
            default: out = i3;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: doc/mux4_arbiter.md
MUX4_ARBITER -- requirements
Module: mux4_arbiter

Interface
REQ-001 Parameter: MAX_HOLD, default 4, maximum consecutive cycles one requester keeps the grant; legal range 1..16.
REQ-002 clock  input  1  single clock; all state updates on posedge clock.
REQ-003 clear  input  1  asynchronous, active-low reset; takes effect on negedge clear without waiting for clock.
REQ-004 req  input  4  request lines; req[n] belongs to requester n (0..3).
REQ-005 i0, i1, i2, i3  input  1 each  data inputs of the shared 4-to-1 path; requester n drives in.
REQ-006 gnt  output  4  registered one-hot grant; all-zero when no requester owns the path.
REQ-007 s1, s0  output  1 each  registered select pair equal to the binary index of the owner ({s1,s0}=2'b10 selects i2).
REQ-008 valid  output  1  registered; high exactly when gnt is non-zero.
REQ-009 out  output  1  shared output; equals the input selected by {s1,s0} while valid=1, otherwise 0.

Function
REQ-010 The block SHALL implement two states: IDLE (no owner) and GRANT (one owner).
REQ-011 Priority SHALL be round-robin: search starts at requester (last_owner+1) mod 4 and wraps upward; the first requester found with req high wins.
REQ-012 IDLE: if any req bit is high at a posedge, the block SHALL enter GRANT at that edge with gnt, s1/s0 and valid updated at the same edge (one-cycle latency from sampled req to visible grant).
REQ-013 IDLE with req=4'b0000 SHALL stay in IDLE, with gnt=0, valid=0 and s1/s0 unchanged.
REQ-014 On every new grant, last_owner SHALL update to the granted index and hold_cnt SHALL load 0.
REQ-015 GRANT: while req[owner]=1 and hold_cnt < MAX_HOLD-1, the grant SHALL be held and hold_cnt SHALL increment by 1 each cycle.
REQ-016 GRANT release: a release occurs when req[owner]=0 or hold_cnt = MAX_HOLD-1; at that edge the block SHALL re-arbitrate using the updated last_owner.
REQ-017 On release, if any req bit is high, the block SHALL grant the winner at that same edge (no idle bubble); otherwise it SHALL enter IDLE with gnt=0 and valid=0.
REQ-018 On release caused by hold expiry, when only the expiring owner still requests, the block SHALL re-grant that owner with hold_cnt reset to 0.
REQ-019 With MAX_HOLD=1, each grant SHALL last exactly one cycle.
REQ-020 Requests from non-owners SHALL never pre-empt a grant before release.
REQ-021 gnt SHALL always be one-hot or zero; s1/s0 SHALL always match the gnt index while valid=1.
REQ-022 hold_cnt SHALL be 4 bits wide and SHALL never exceed MAX_HOLD-1.
REQ-023 out SHALL be combinational from i0..i3, s1, s0 and valid, with no added latency.

Reset
REQ-024 While clear=0, the outputs SHALL be gnt=4'b0000, valid=0, s1=0, s0=0 and out=0; the state SHALL be IDLE, hold_cnt=0 and last_owner=3, so requester 0 has first priority.
REQ-025 Assertion of clear during GRANT SHALL drop the grant immediately (asynchronously); after release of clear, the first arbitration SHALL follow REQ-024 priority.
REQ-026 Release of clear SHALL be synchronised by the environment; the block SHALL NOT grant on the edge coincident with clear rising.

Verification
REQ-027 Reset then req=4'b1111 held, MAX_HOLD=4 -> gnt sequence 0001 x4, 0010 x4, 0100 x4, 1000 x4, 0001..., with no idle cycles between grants.
REQ-028 req=4'b0100 for 2 cycles then 0 -> gnt=0100 with {s1,s0}=10 for 2 cycles, then IDLE with valid=0 and out=0.
REQ-029 i0=1, i1=0, i2=1, i3=0 with each requester granted in turn -> out = 1, 0, 1, 0 respectively while valid=1.
REQ-030 Owner 1 holding with req=4'b0010 only, MAX_HOLD=4 -> grant released after 4 cycles and immediately re-granted to 1 with hold_cnt=0.
REQ-031 clear pulsed low mid-grant of requester 2 -> gnt=0 and valid=0 before the next clock edge; after clear goes high with req=4'b1100, requester 2 is granted first.
REQ-032 Owner 3 drops req while req=4'b0011 -> the next grant goes to requester 0 (wrap-around) at the same edge.
